sram_ctrl: RTL and testbench

- Synchronous bus-to-asynchronous-SRAM controller, directly upstream of the 128K x 8 SRAM on the machine board.
- Accepts 16-bit word reads and writes from the CPU bus on a strobe/ack handshake.
- Splits each word into two byte cycles and generates glitch-free registered CE/CE2/WE/OE/address/data with configurable wait states, meeting the SRAM's 55 ns cycle.

---
 rtl/sram_pkg.sv | 22 ++
 rtl/sram_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_sram_ctrl.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for sram_ctrl: FSM state encoding, default strobe width and byte lanes.
package sram_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StStrobe,
      StRecover,
      StDone
   } state_e;

   localparam int unsigned WAIT_CYCLES_DEF = 3;

   localparam logic LANE_LO = 1'b0;
   localparam logic LANE_HI = 1'b1;

   // Little-endian lane select: lane 0 is bits 7:0, lane 1 is bits 15:8.
   function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
      return lane ? word[15:8] : word[7:0];
   endfunction

endpackage

// File: rtl/sram_ctrl.sv
// CPU-bus to asynchronous 8-bit SRAM controller; each 16-bit word is split into two byte cycles.
// Optional per-byte enables are compiled in with `define SRAM_BYTE_EN.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int unsigned ADDR_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [15:0]       cpu_wdata,
`ifdef SRAM_BYTE_EN
   input  logic [1:0]        cpu_be,
`endif
   output logic [15:0]       cpu_rdata,
   output logic              cpu_ack,
   output logic              busy,
   output logic [ADDR_W:0]   sram_a,
   output logic [7:0]        sram_dq_o,
   output logic              sram_dq_oe,
   input  logic [7:0]        sram_dq_i,
   output logic              sram_ce_n,
   output logic              sram_ce2,
   output logic              sram_we_n,
   output logic              sram_oe_n
);

   localparam logic [3:0] STROBE_LAST = 4'(WAIT_CYCLES - 1);

   state_e state_q, state_d;

   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              be_hi_q, be_hi_d;
   logic              lane_q, lane_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [15:0]       rbuf_q, rbuf_d;
   logic [15:0]       rdata_q, rdata_d;
   logic              ack_q, ack_d;
   logic              busy_q;

   logic [ADDR_W:0]   a_q, a_d;
   logic [7:0]        dq_o_q, dq_o_d;
   logic              dq_oe_q, dq_oe_d;
   logic              ce_n_q, ce_n_d;
   logic              we_n_q, we_n_d;
   logic              oe_n_q, oe_n_d;

   logic [1:0]        req_be;
   logic              enter_setup;
   logic              go_done;

`ifdef SRAM_BYTE_EN
   assign req_be = cpu_be;
`else
   assign req_be = 2'b11;
`endif

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_hi_d     = be_hi_q;
      lane_d      = lane_q;
      cnt_d       = cnt_q;
      rbuf_d      = rbuf_q;
      rdata_d     = rdata_q;
      ack_d       = 1'b0;
      a_d         = a_q;
      dq_o_d      = dq_o_q;
      dq_oe_d     = dq_oe_q;
      ce_n_d      = ce_n_q;
      we_n_d      = 1'b1;
      oe_n_d      = 1'b1;
      enter_setup = 1'b0;
      go_done     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cpu_req) begin
               we_d    = cpu_we;
               addr_d  = cpu_addr;
               wdata_d = cpu_wdata;
               be_hi_d = req_be[LANE_HI];
               // Seed with the current read data so skipped lanes keep their old value.
               rbuf_d  = rdata_q;
               if (req_be == 2'b00) begin
                  go_done = 1'b1;
               end else begin
                  lane_d      = req_be[LANE_LO] ? LANE_LO : LANE_HI;
                  enter_setup = 1'b1;
               end
            end
         end
         StSetup: begin
            state_d = StStrobe;
            cnt_d   = STROBE_LAST;
            if (we_q) begin
               we_n_d = 1'b0;
            end else begin
               oe_n_d = 1'b0;
            end
         end
         StStrobe: begin
            if (cnt_q == 4'd0) begin
               state_d = StRecover;
               if (!we_q) begin
                  if (lane_q == LANE_HI) begin
                     rbuf_d[15:8] = sram_dq_i;
                  end else begin
                     rbuf_d[7:0] = sram_dq_i;
                  end
               end
            end else begin
               cnt_d  = cnt_q - 4'd1;
               we_n_d = we_n_q;
               oe_n_d = oe_n_q;
            end
         end
         StRecover: begin
            if (lane_q == LANE_LO && be_hi_q) begin
               lane_d      = LANE_HI;
               enter_setup = 1'b1;
            end else begin
               go_done = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Output registers are loaded from the upcoming state so every pin is a flop output.
      if (enter_setup) begin
         state_d = StSetup;
         a_d     = {addr_d, lane_d};
         ce_n_d  = 1'b0;
         dq_oe_d = we_d;
         if (we_d) begin
            dq_o_d = lane_byte(wdata_d, lane_d);
         end
      end

      if (go_done) begin
         state_d = StDone;
         ce_n_d  = 1'b1;
         dq_oe_d = 1'b0;
         ack_d   = 1'b1;
         if (!we_d) begin
            rdata_d = rbuf_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_hi_q <= 1'b0;
         lane_q  <= LANE_LO;
         cnt_q   <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         a_q     <= '0;
         dq_o_q  <= '0;
         dq_oe_q <= 1'b0;
         ce_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_hi_q <= be_hi_d;
         lane_q  <= lane_d;
         cnt_q   <= cnt_d;
         rbuf_q  <= rbuf_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         busy_q  <= (state_d != StIdle);
         a_q     <= a_d;
         dq_o_q  <= dq_o_d;
         dq_oe_q <= dq_oe_d;
         ce_n_q  <= ce_n_d;
         we_n_q  <= we_n_d;
         oe_n_q  <= oe_n_d;
      end
   end

   assign cpu_rdata  = rdata_q;
   assign cpu_ack    = ack_q;
   assign busy       = busy_q;
   assign sram_a     = a_q;
   assign sram_dq_o  = dq_o_q;
   assign sram_dq_oe = dq_oe_q;
   assign sram_ce_n  = ce_n_q;
   assign sram_ce2   = 1'b1;
   assign sram_we_n  = we_n_q;
   assign sram_oe_n  = oe_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: behavioural SRAM with pad wrapper plus a word-level reference model.
module tb_sram_ctrl;

   localparam int unsigned WAIT     = 3;
   localparam int unsigned AW       = 16;
   localparam int unsigned BYTE_LAT = WAIT + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [15:0]   cpu_wdata = '0;
   logic [1:0]    cpu_be = 2'b11;
   logic [15:0]   cpu_rdata;
   logic          cpu_ack, busy;
   logic [AW:0]   sram_a;
   logic [7:0]    sram_dq_o, sram_dq_i;
   logic          sram_dq_oe, ce_n, ce2, we_n, oe_n;

   int total = 0;
   int bad   = 0;

   sram_ctrl #(.WAIT_CYCLES(WAIT), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
`ifdef SRAM_BYTE_EN
      .cpu_be    (cpu_be),
`endif
      .cpu_rdata (cpu_rdata),
      .cpu_ack   (cpu_ack),
      .busy      (busy),
      .sram_a    (sram_a),
      .sram_dq_o (sram_dq_o),
      .sram_dq_oe(sram_dq_oe),
      .sram_dq_i (sram_dq_i),
      .sram_ce_n (ce_n),
      .sram_ce2  (ce2),
      .sram_we_n (we_n),
      .sram_oe_n (oe_n)
   );

   always #5 clk = ~clk;

   // ---------------- SRAM behavioural model and pad wrapper ----------------
   logic [7:0] sram_mem [int];
   logic [7:0] ref_mem  [int];
   logic [15:0] ref_rdata = 16'h0000;

   function automatic logic [7:0] init_byte(input int a);
      return 8'(a * 37 + 11) ^ 8'(a >> 8);
   endfunction

   function automatic logic [7:0] sram_rd(input int a);
      return sram_mem.exists(a) ? sram_mem[a] : init_byte(a);
   endfunction

   function automatic logic [7:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
   endfunction

   function automatic logic [1:0] eff_be(input logic [1:0] be);
`ifdef SRAM_BYTE_EN
      return be;
`else
      return 2'b11;
`endif
   endfunction

   assign sram_dq_i = sram_dq_oe ? sram_dq_o :
                      ((!ce_n && !oe_n && we_n) ? sram_rd(int'(sram_a)) : 8'hFF);

   int we_run = 0, oe_run = 0, we_pulses = 0, oe_pulses = 0, dqoe_cycles = 0, acks = 0;
   logic prev_we_n = 1'b1, prev_oe_n = 1'b1;
   logic [AW:0] prev_a = '0;

   // Bus-protocol monitor; the SRAM commits a byte only when WE rises while CE is still low.
   always @(negedge clk) begin
      if (!rst) begin
         if (!we_n || !oe_n) begin
            total++;
            if (sram_dq_oe && !oe_n) begin
               bad++;
               $display("FAIL pad_clash: dq_oe=%0b with oe_n=%0b, required dq_oe=0", sram_dq_oe, oe_n);
            end
            if ((!prev_we_n && !we_n) || (!prev_oe_n && !oe_n)) begin
               total++;
               if (sram_a !== prev_a) begin
                  bad++;
                  $display("FAIL addr_stable: a=%h during strobe, required %h", sram_a, prev_a);
               end
            end
         end
         if (!we_n) we_run++;
         if (!oe_n) oe_run++;
         if (prev_we_n === 1'b0 && we_n === 1'b1 && ce_n === 1'b0) begin
            we_pulses++;
            total++;
            if (we_run != WAIT) begin
               bad++;
               $display("FAIL we_width: got %0d cycles, required %0d", we_run, WAIT);
            end
            total++;
            if (sram_dq_oe !== 1'b1) begin
               bad++;
               $display("FAIL write_drive: dq_oe=%0b at WE rise, required 1", sram_dq_oe);
            end
            sram_mem[int'(sram_a)] = sram_dq_o;
         end
         if (prev_oe_n === 1'b0 && oe_n === 1'b1 && ce_n === 1'b0) begin
            oe_pulses++;
            total++;
            if (oe_run != WAIT) begin
               bad++;
               $display("FAIL oe_width: got %0d cycles, required %0d", oe_run, WAIT);
            end
         end
         if (we_n) we_run = 0;
         if (oe_n) oe_run = 0;
         if (sram_dq_oe) dqoe_cycles++;
         if (cpu_ack) acks++;
      end else begin
         we_run = 0;
         oe_run = 0;
      end
      prev_we_n = we_n;
      prev_oe_n = oe_n;
      prev_a    = sram_a;
   end

   // ---------------- Reference model ----------------
   task automatic model_access(input logic we, input logic [AW-1:0] addr, input logic [15:0] wd,
                               input logic [1:0] be, output logic [15:0] exp_rd, output int exp_lat);
      logic [1:0] eb;
      int ba;
      eb = eff_be(be);
      ba = 2 * int'(addr);
      exp_lat = (int'(eb[0]) + int'(eb[1])) * BYTE_LAT + 1;
      if (we) begin
         if (eb[0]) ref_mem[ba]     = wd[7:0];
         if (eb[1]) ref_mem[ba + 1] = wd[15:8];
      end else begin
         if (eb[0]) ref_rdata[7:0]  = ref_rd(ba);
         if (eb[1]) ref_rdata[15:8] = ref_rd(ba + 1);
      end
      exp_rd = ref_rdata;
   endtask

   // Presents one request in the next cycle and returns at the negedge of the ack cycle.
   task automatic access(input logic we, input logic [AW-1:0] addr, input logic [15:0] wd,
                         input logic [1:0] be, output logic [15:0] rd, output int lat);
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wd;
      cpu_be    = be;
      @(posedge clk);
      @(negedge clk);
      cpu_req   = 1'b0;
      cpu_we    = 1'($urandom);
      cpu_addr  = AW'($urandom);
      cpu_wdata = 16'($urandom);
      lat = 1;
      while (!cpu_ack && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      rd = cpu_rdata;
   endtask

   // ---------------- Tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      cpu_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if ({ce_n, we_n, oe_n} !== 3'b111) begin
         bad++;
         $display("FAIL reset_strobes: ce_n/we_n/oe_n=%b, required 111", {ce_n, we_n, oe_n});
      end
      total++;
      if ({sram_dq_oe, busy, cpu_ack} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags: dq_oe/busy/ack=%b, required 000", {sram_dq_oe, busy, cpu_ack});
      end
      total++;
      if (sram_a !== '0 || sram_dq_o !== 8'h00 || cpu_rdata !== 16'h0000) begin
         bad++;
         $display("FAIL reset_data: a=%h dq_o=%h rdata=%h, required 0", sram_a, sram_dq_o, cpu_rdata);
      end
      total++;
      if (ce2 !== 1'b1) begin
         bad++;
         $display("FAIL ce2: got %b, required 1", ce2);
      end
      rst = 1'b0;
   endtask

   task automatic test_write();
      logic [15:0] rd, exp_rd;
      int lat, exp_lat, w0, o0;
      w0 = we_pulses;
      o0 = oe_pulses;
      model_access(1'b1, 16'h0005, 16'hA5F0, 2'b11, exp_rd, exp_lat);
      access(1'b1, 16'h0005, 16'hA5F0, 2'b11, rd, lat);
      total++;
      if (lat != 11) begin
         bad++;
         $display("FAIL write_latency: ack at cycle %0d, required 11", lat);
      end
      total++;
      if (sram_rd(32'h0A) !== 8'hF0 || sram_rd(32'h0B) !== 8'hA5) begin
         bad++;
         $display("FAIL write_bytes: 0A=%h 0B=%h, required F0 A5", sram_rd(32'h0A), sram_rd(32'h0B));
      end
      total++;
      if (we_pulses - w0 != 2 || oe_pulses != o0) begin
         bad++;
         $display("FAIL write_pulses: we=%0d oe=%0d, required 2 0", we_pulses - w0, oe_pulses - o0);
      end
      total++;
      if (rd !== exp_rd) begin
         bad++;
         $display("FAIL write_keeps_rdata: got %h, required %h", rd, exp_rd);
      end
   endtask

   task automatic test_read();
      logic [15:0] rd, exp_rd;
      int lat, exp_lat, o0, d0;
      o0 = oe_pulses;
      d0 = dqoe_cycles;
      model_access(1'b0, 16'h0005, 16'h0000, 2'b11, exp_rd, exp_lat);
      access(1'b0, 16'h0005, 16'h0000, 2'b11, rd, lat);
      total++;
      if (rd !== 16'hA5F0) begin
         bad++;
         $display("FAIL read_data: got %h, required A5F0", rd);
      end
      total++;
      if (lat != exp_lat) begin
         bad++;
         $display("FAIL read_latency: ack at cycle %0d, required %0d", lat, exp_lat);
      end
      total++;
      if (oe_pulses - o0 != 2 || dqoe_cycles != d0) begin
         bad++;
         $display("FAIL read_bus: oe pulses=%0d dq_oe cycles=%0d, required 2 0",
                  oe_pulses - o0, dqoe_cycles - d0);
      end
   endtask

   task automatic test_random();
      logic [15:0] rd, exp_rd, wd;
      logic [AW-1:0] addr;
      logic [1:0] be;
      logic we;
      int lat, exp_lat;
      for (int i = 0; i < 30; i++) begin
         we   = 1'($urandom);
         addr = AW'($urandom_range(0, 31));
         wd   = 16'($urandom);
`ifdef SRAM_BYTE_EN
         be   = 2'($urandom_range(0, 3));
`else
         be   = 2'b11;
`endif
         model_access(we, addr, wd, be, exp_rd, exp_lat);
         access(we, addr, wd, be, rd, lat);
         total++;
         if (rd !== exp_rd) begin
            bad++;
            $display("FAIL rand_rdata[%0d]: we=%0b addr=%h be=%b got %h, required %h",
                     i, we, addr, be, rd, exp_rd);
         end
         total++;
         if (lat != exp_lat) begin
            bad++;
            $display("FAIL rand_latency[%0d]: got %0d, required %0d", i, lat, exp_lat);
         end
      end
      for (int a = 0; a < 64; a++) begin
         total++;
         if (sram_rd(a) !== ref_rd(a)) begin
            bad++;
            $display("FAIL rand_mem[%0h]: got %h, required %h", a, sram_rd(a), ref_rd(a));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] rd1, rd2, exp_rd, wd;
      int lat1, lat2, exp_lat, a0;
      wd = 16'($urandom);
      a0 = acks;
      model_access(1'b1, 16'h0020, wd, 2'b11, exp_rd, exp_lat);
      fork
         access(1'b1, 16'h0020, wd, 2'b11, rd1, lat1);
         begin
            repeat (4) @(negedge clk);
            cpu_req   = 1'b1;
            cpu_we    = 1'b1;
            cpu_addr  = 16'h0030;
            cpu_wdata = 16'hDEAD;
            @(negedge clk);
            cpu_req   = 1'b0;
         end
      join
      model_access(1'b0, 16'h0020, 16'h0000, 2'b11, exp_rd, exp_lat);
      access(1'b0, 16'h0020, 16'h0000, 2'b11, rd2, lat2);
      total++;
      if (lat2 != exp_lat) begin
         bad++;
         $display("FAIL b2b_latency: second ack at cycle %0d, required %0d", lat2, exp_lat);
      end
      total++;
      if (rd2 !== wd) begin
         bad++;
         $display("FAIL b2b_read: got %h, required %h", rd2, wd);
      end
      total++;
      if (acks - a0 != 2) begin
         bad++;
         $display("FAIL b2b_acks: got %0d acks, required 2", acks - a0);
      end
      total++;
      if (sram_rd(32'h60) !== ref_rd(32'h60) || sram_rd(32'h61) !== ref_rd(32'h61)) begin
         bad++;
         $display("FAIL b2b_dropped: 60=%h 61=%h, required %h %h", sram_rd(32'h60),
                  sram_rd(32'h61), ref_rd(32'h60), ref_rd(32'h61));
      end
   endtask

   task automatic test_reset_mid();
      logic seen_ack;
      int n;
      @(negedge clk);
      cpu_req   = 1'b1;
      cpu_we    = 1'b1;
      cpu_addr  = 16'h0010;
      cpu_wdata = 16'h1234;
      @(posedge clk);
      seen_ack = 1'b0;
      for (n = 1; n <= 9; n++) begin
         @(negedge clk);
         if (n == 1) cpu_req = 1'b0;
         if (cpu_ack) seen_ack = 1'b1;
         if (n == 7) begin
            total++;
            if (we_n !== 1'b0) begin
               bad++;
               $display("FAIL rst_mid_pre: we_n=%b in odd-byte strobe, required 0", we_n);
            end
            rst = 1'b1;
         end
         if (n == 8) begin
            total++;
            if (we_n !== 1'b1 || ce_n !== 1'b1 || busy !== 1'b0) begin
               bad++;
               $display("FAIL rst_mid_idle: we_n=%b ce_n=%b busy=%b, required 1 1 0", we_n, ce_n,
                        busy);
            end
         end
         if (n == 9) rst = 1'b0;
      end
      repeat (15) begin
         @(negedge clk);
         if (cpu_ack) seen_ack = 1'b1;
      end
      ref_mem[32'h20] = 8'h34;
      ref_rdata = 16'h0000;
      total++;
      if (seen_ack !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid_ack: ack seen=%b, required 0", seen_ack);
      end
      total++;
      if (sram_rd(32'h21) !== ref_rd(32'h21) || sram_rd(32'h20) !== 8'h34) begin
         bad++;
         $display("FAIL rst_mid_mem: 20=%h 21=%h, required 34 %h", sram_rd(32'h20), sram_rd(32'h21),
                  ref_rd(32'h21));
      end
      total++;
      if (cpu_rdata !== 16'h0000) begin
         bad++;
         $display("FAIL rst_mid_rdata: got %h, required 0000", cpu_rdata);
      end
   endtask

`ifdef SRAM_BYTE_EN
   task automatic test_byte_en();
      logic [15:0] rd, exp_rd;
      int lat, exp_lat, w0;
      w0 = we_pulses;
      model_access(1'b1, 16'h0002, 16'hBEEF, 2'b10, exp_rd, exp_lat);
      access(1'b1, 16'h0002, 16'hBEEF, 2'b10, rd, lat);
      total++;
      if (lat != 6) begin
         bad++;
         $display("FAIL be_hi_latency: ack at cycle %0d, required 6", lat);
      end
      total++;
      if (sram_rd(5) !== 8'hBE || sram_rd(4) !== ref_rd(4) || we_pulses - w0 != 1) begin
         bad++;
         $display("FAIL be_hi_mem: 4=%h 5=%h pulses=%0d, required %h BE 1", sram_rd(4), sram_rd(5),
                  we_pulses - w0, ref_rd(4));
      end
      w0 = we_pulses;
      model_access(1'b1, 16'h0003, 16'h5555, 2'b00, exp_rd, exp_lat);
      access(1'b1, 16'h0003, 16'h5555, 2'b00, rd, lat);
      total++;
      if (lat != 1 || we_pulses != w0) begin
         bad++;
         $display("FAIL be_none: lat=%0d pulses=%0d, required 1 0", lat, we_pulses - w0);
      end
      model_access(1'b0, 16'h0002, 16'h0000, 2'b01, exp_rd, exp_lat);
      access(1'b0, 16'h0002, 16'h0000, 2'b01, rd, lat);
      total++;
      if (rd !== exp_rd || lat != exp_lat) begin
         bad++;
         $display("FAIL be_lo_read: rd=%h lat=%0d, required %h %0d", rd, lat, exp_rd, exp_lat);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_random();
      test_reset_mid();
`ifdef SRAM_BYTE_EN
      test_byte_en();
`endif
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
